// File: rtl/ulpi_rx_ctrl.sv
// ULPI receive controller: turnaround tracking, RX CMD decode, packet framing.
// Optional statistics counters are enabled by defining ULPI_RX_STATS_EN.
module ulpi_rx_ctrl #(
   parameter int unsigned MAX_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  usb_in,
   input  logic        dir,
   input  logic        nxt,
   output logic [7:0]  data_out,
   output logic        data_valid,
   output logic        pkt_start,
   output logic        pkt_end,
   output logic        pkt_err,
   output logic [10:0] byte_count,
   output logic [1:0]  linestate,
   output logic        rx_active,
   output logic [15:0] pkt_cnt,
   output logic [15:0] err_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      TURN,
      RECV,
      DROP,
      DONE
   } state_t;

   localparam logic [10:0] MAXC = 11'(MAX_BYTES);

   state_t      state_q, state_d;
   logic        dir_q;
   logic        err_q, err_d;
   logic        got_q, got_d;
   logic [10:0] cnt_q, cnt_d;
   logic [7:0]  data_q, data_d;
   logic        dv_q, dv_d;
   logic        ps_q, ps_d;
   logic        pe_q, pe_d;
   logic        perr_q, perr_d;
   logic [1:0]  ls_q, ls_d;
   logic        act_q, act_d;

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      got_d   = got_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      dv_d    = 1'b0;
      ps_d    = 1'b0;
      pe_d    = 1'b0;
      perr_d  = 1'b0;
      ls_d    = ls_q;
      act_d   = act_q;
      unique case (state_q)
         IDLE: begin
            if (dir && !dir_q) state_d = TURN;
         end
         TURN: begin
            got_d   = 1'b0;
            state_d = dir ? RECV : IDLE;
         end
         RECV: begin
            if (!dir) begin
               state_d = DONE;
            end else if (!nxt) begin
               ls_d  = usb_in[1:0];
               act_d = (usb_in[5:4] == 2'b01);
               if (usb_in[5:4] == 2'b11) err_d = 1'b1;
            end else if (got_q && cnt_q == MAXC) begin
               err_d   = 1'b1;
               state_d = DROP;
            end else begin
               data_d = usb_in;
               dv_d   = 1'b1;
               ps_d   = !got_q;
               got_d  = 1'b1;
               cnt_d  = got_q ? cnt_q + 11'd1 : 11'd1;
            end
         end
         DROP: begin
            if (!dir) state_d = DONE;
         end
         DONE: begin
            pe_d    = got_q;
            perr_d  = got_q & err_q;
            err_d   = 1'b0;
            got_d   = 1'b0;
            state_d = dir ? TURN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // dir_q resets high so a bus already owned at release is not an edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         dir_q   <= 1'b1;
         err_q   <= 1'b0;
         got_q   <= 1'b0;
         cnt_q   <= '0;
         data_q  <= '0;
         dv_q    <= 1'b0;
         ps_q    <= 1'b0;
         pe_q    <= 1'b0;
         perr_q  <= 1'b0;
         ls_q    <= '0;
         act_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir;
         err_q   <= err_d;
         got_q   <= got_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         dv_q    <= dv_d;
         ps_q    <= ps_d;
         pe_q    <= pe_d;
         perr_q  <= perr_d;
         ls_q    <= ls_d;
         act_q   <= act_d;
      end
   end

   assign data_out   = data_q;
   assign data_valid = dv_q;
   assign pkt_start  = ps_q;
   assign pkt_end    = pe_q;
   assign pkt_err    = perr_q;
   assign byte_count = cnt_q;
   assign linestate  = ls_q;
   assign rx_active  = act_q;

`ifdef ULPI_RX_STATS_EN
   logic [15:0] pkt_cnt_q;
   logic [15:0] err_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         if (pe_d) pkt_cnt_q <= pkt_cnt_q + 16'd1;
         if (pe_d && perr_d) err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign pkt_cnt = pkt_cnt_q;
   assign err_cnt = err_cnt_q;
`else
   assign pkt_cnt = '0;
   assign err_cnt = '0;
`endif

endmodule
